// File: rtl/prog_run_ctrl.sv
// Run controller: Start/Ack handshake, per-slot program launch, issue gating,
// cycle/retired counters and optional watchdog.
module prog_run_ctrl #(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned NUM_PROG = 4,
  parameter int unsigned SEL_W    = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1,
  parameter logic [NUM_PROG*PC_W-1:0] PROG_BASE = '0,
  parameter int unsigned TIMEOUT  = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [SEL_W-1:0] ProgSel,
  input  logic             HaltReq,
  input  logic             Stall,
  output logic             Run,
  output logic             PcLoad,
  output logic [PC_W-1:0]  PcLoadAddr,
  output logic             Ack,
  output logic             TimedOut,
  output logic [CNT_W-1:0] CycleCount,
  output logic [CNT_W-1:0] RetiredCount
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_nxt;
  logic              run_nxt, ack_nxt, to_nxt;
  logic [CNT_W-1:0]  cyc_nxt, ret_nxt;
  logic [PC_W-1:0]   base_sel;
  logic              halt_q, timeout_hit;

  // Out-of-range slot selects fall back to slot 0.
  always_comb begin
    base_sel = PROG_BASE[PC_W-1:0];
    for (int unsigned i = 0; i < NUM_PROG; i++) begin
      if (ProgSel == SEL_W'(i)) base_sel = PROG_BASE[i*PC_W +: PC_W];
    end
  end

  always_comb begin
    state_nxt   = state;
    cyc_nxt     = CycleCount;
    ret_nxt     = RetiredCount;
    to_nxt      = TimedOut;
    PcLoad      = 1'b0;
    PcLoadAddr  = '0;
    halt_q      = HaltReq & ~Stall;
    timeout_hit = 1'b0;
    if (TIMEOUT != 0) timeout_hit = (32'(CycleCount) == TIMEOUT - 32'd1);

    case (state)
      IDLE: begin
        if (Start) state_nxt = ARM;
      end
      ARM: begin
        PcLoad     = 1'b1;
        PcLoadAddr = base_sel;
        cyc_nxt    = '0;
        ret_nxt    = '0;
        to_nxt     = 1'b0;
        if (!Start) state_nxt = RUN;
      end
      RUN: begin
        if (Start) begin
          // Abort: relaunch without acknowledging.
          state_nxt = ARM;
          cyc_nxt   = '0;
          ret_nxt   = '0;
          to_nxt    = 1'b0;
        end else begin
          if (CycleCount != CNT_MAX) cyc_nxt = CycleCount + CNT_W'(1);
          if (!Stall && RetiredCount != CNT_MAX) ret_nxt = RetiredCount + CNT_W'(1);
          if (halt_q) begin
            state_nxt = DONE;
          end else if (timeout_hit) begin
            state_nxt = DONE;
            to_nxt    = 1'b1;
          end
        end
      end
      DONE: begin
        if (Start) begin
          state_nxt = ARM;
          cyc_nxt   = '0;
          ret_nxt   = '0;
          to_nxt    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (Reset) begin
      PcLoad     = 1'b0;
      PcLoadAddr = '0;
    end

    run_nxt = (state_nxt == RUN);
    ack_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      Run          <= 1'b0;
      Ack          <= 1'b0;
      TimedOut     <= 1'b0;
      CycleCount   <= '0;
      RetiredCount <= '0;
    end else begin
      state        <= state_nxt;
      Run          <= run_nxt;
      Ack          <= ack_nxt;
      TimedOut     <= to_nxt;
      CycleCount   <= cyc_nxt;
      RetiredCount <= ret_nxt;
    end
  end

endmodule
